// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, drives the instruction ROM, and loads the IF/ID register.
// Branches redirect and flush; stalls freeze the PC and IF/ID together.
module inst_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP_INST = 16'h0000,
   parameter logic [15:0] PC_STEP  = 16'd2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_flag,
   input  logic [15:0] branch_target,
   output logic        rom_ce,
   output logic [15:0] rom_addr,
   input  logic [15:0] rom_inst,
   output logic [15:0] id_pc,
   output logic [15:0] id_inst,
   output logic        id_valid,
   output logic [15:0] fetch_count,
   output logic        misalign_err
);

   logic [15:0] pc;

   // Address comes straight from the PC register, so redirects land one edge later.
   assign rom_addr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_PC;
         rom_ce       <= 1'b0;
         id_pc        <= 16'h0000;
         id_inst      <= NOP_INST;
         id_valid     <= 1'b0;
         fetch_count  <= 16'h0000;
         misalign_err <= 1'b0;
      end else begin
         rom_ce       <= 1'b1;
         misalign_err <= 1'b0;
         if (branch_flag) begin
            // Redirect wins over stall; the wrong-path fetch is squashed.
            pc           <= {branch_target[15:1], 1'b0};
            misalign_err <= branch_target[0];
            id_pc        <= pc;
            id_inst      <= NOP_INST;
            id_valid     <= 1'b0;
         end else if (!stall) begin
            if (rom_ce)
               pc <= pc + PC_STEP;
            id_pc    <= pc;
            id_inst  <= rom_ce ? rom_inst : NOP_INST;
            id_valid <= rom_ce;
            if (rom_ce)
               fetch_count <= fetch_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a combinational ROM model.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst, stall, branch_flag;
   logic [15:0] branch_target;
   logic        rom_ce;
   logic [15:0] rom_addr, rom_inst;
   logic [15:0] id_pc, id_inst;
   logic        id_valid;
   logic [15:0] fetch_count;
   logic        misalign_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] rom_f(input logic [15:0] a);
      case (a)
         16'h0000: rom_f = 16'h1111;
         16'h0002: rom_f = 16'h2222;
         default:  rom_f = a ^ 16'hA5A5;
      endcase
   endfunction

   assign rom_inst = rom_f(rom_addr);

   inst_fetch dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
      .branch_target(branch_target), .rom_ce(rom_ce), .rom_addr(rom_addr),
      .rom_inst(rom_inst), .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
      .fetch_count(fetch_count), .misalign_err(misalign_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 16'h0000;
      step(); step();
      total++; if (rom_ce !== 1'b0) begin bad++; $display("FAIL rst_ce got=%b exp=0", rom_ce); end
      total++; if (rom_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h exp=0000", rom_addr); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", id_valid); end
      total++; if (id_inst !== 16'h0000) begin bad++; $display("FAIL rst_inst got=%h exp=0000", id_inst); end
      total++; if (id_pc !== 16'h0000) begin bad++; $display("FAIL rst_pc got=%h exp=0000", id_pc); end
      total++; if (fetch_count !== 16'h0000) begin bad++; $display("FAIL rst_cnt got=%h exp=0000", fetch_count); end
      total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rst_mis got=%b exp=0", misalign_err); end
      rst = 1'b0;
      step();
      total++; if (rom_ce !== 1'b1) begin bad++; $display("FAIL bubble_ce got=%b exp=1", rom_ce); end
      total++; if (rom_addr !== 16'h0000) begin bad++; $display("FAIL bubble_addr got=%h exp=0000", rom_addr); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL bubble_valid got=%b exp=0", id_valid); end
      total++; if (fetch_count !== 16'h0000) begin bad++; $display("FAIL bubble_cnt got=%h exp=0000", fetch_count); end
   endtask

   task automatic test_fetch();
      step();
      total++; if (rom_addr !== 16'h0002) begin bad++; $display("FAIL f1_addr got=%h exp=0002", rom_addr); end
      total++; if (id_inst !== 16'h1111) begin bad++; $display("FAIL f1_inst got=%h exp=1111", id_inst); end
      total++; if (id_pc !== 16'h0000) begin bad++; $display("FAIL f1_pc got=%h exp=0000", id_pc); end
      total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL f1_valid got=%b exp=1", id_valid); end
      total++; if (fetch_count !== 16'd1) begin bad++; $display("FAIL f1_cnt got=%0d exp=1", fetch_count); end
      step();
      total++; if (rom_addr !== 16'h0004) begin bad++; $display("FAIL f2_addr got=%h exp=0004", rom_addr); end
      total++; if (id_inst !== 16'h2222) begin bad++; $display("FAIL f2_inst got=%h exp=2222", id_inst); end
      total++; if (id_pc !== 16'h0002) begin bad++; $display("FAIL f2_pc got=%h exp=0002", id_pc); end
      total++; if (fetch_count !== 16'd2) begin bad++; $display("FAIL f2_cnt got=%0d exp=2", fetch_count); end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         total++; if (rom_addr !== 16'h0004) begin bad++; $display("FAIL stall_addr[%0d] got=%h exp=0004", i, rom_addr); end
         total++; if (id_inst !== 16'h2222 || id_pc !== 16'h0002 || id_valid !== 1'b1)
            begin bad++; $display("FAIL stall_id[%0d] got=%h/%h/%b exp=2222/0002/1", i, id_inst, id_pc, id_valid); end
         total++; if (fetch_count !== 16'd2) begin bad++; $display("FAIL stall_cnt[%0d] got=%0d exp=2", i, fetch_count); end
      end
      stall = 1'b0;
      step();
      total++; if (rom_addr !== 16'h0006) begin bad++; $display("FAIL resume_addr got=%h exp=0006", rom_addr); end
      total++; if (id_inst !== 16'hA5A1 || id_pc !== 16'h0004) begin bad++; $display("FAIL resume_id got=%h/%h exp=a5a1/0004", id_inst, id_pc); end
      total++; if (fetch_count !== 16'd3) begin bad++; $display("FAIL resume_cnt got=%0d exp=3", fetch_count); end
   endtask

   task automatic test_branch();
      branch_flag = 1'b1; stall = 1'b1; branch_target = 16'h0040;
      step();
      branch_flag = 1'b0; stall = 1'b0;
      total++; if (rom_addr !== 16'h0040) begin bad++; $display("FAIL br_addr got=%h exp=0040", rom_addr); end
      total++; if (id_valid !== 1'b0 || id_inst !== 16'h0000) begin bad++; $display("FAIL br_flush got=%b/%h exp=0/0000", id_valid, id_inst); end
      total++; if (id_pc !== 16'h0006) begin bad++; $display("FAIL br_idpc got=%h exp=0006", id_pc); end
      total++; if (fetch_count !== 16'd3) begin bad++; $display("FAIL br_cnt got=%0d exp=3", fetch_count); end
      total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL br_mis got=%b exp=0", misalign_err); end
      step();
      total++; if (id_inst !== 16'hA5E5 || id_pc !== 16'h0040 || id_valid !== 1'b1)
         begin bad++; $display("FAIL br_tgt got=%h/%h/%b exp=a5e5/0040/1", id_inst, id_pc, id_valid); end
      total++; if (rom_addr !== 16'h0042) begin bad++; $display("FAIL br_next got=%h exp=0042", rom_addr); end
      total++; if (fetch_count !== 16'd4) begin bad++; $display("FAIL br_cnt2 got=%0d exp=4", fetch_count); end
   endtask

   task automatic test_misalign();
      branch_flag = 1'b1; branch_target = 16'h0041;
      step();
      branch_flag = 1'b0;
      total++; if (rom_addr !== 16'h0040) begin bad++; $display("FAIL mis_addr got=%h exp=0040", rom_addr); end
      total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b exp=1", misalign_err); end
      step();
      total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", misalign_err); end
      total++; if (id_inst !== 16'hA5E5 || fetch_count !== 16'd5) begin bad++; $display("FAIL mis_fetch got=%h/%0d exp=a5e5/5", id_inst, fetch_count); end
   endtask

   task automatic test_wrap_and_reset();
      branch_flag = 1'b1; branch_target = 16'hFFFE;
      step();
      branch_flag = 1'b0;
      total++; if (rom_addr !== 16'hFFFE) begin bad++; $display("FAIL wrap_addr0 got=%h exp=fffe", rom_addr); end
      step();
      total++; if (rom_addr !== 16'h0000) begin bad++; $display("FAIL wrap_addr1 got=%h exp=0000", rom_addr); end
      total++; if (id_inst !== 16'h5A5B || id_pc !== 16'hFFFE) begin bad++; $display("FAIL wrap_id got=%h/%h exp=5a5b/fffe", id_inst, id_pc); end
      total++; if (fetch_count !== 16'd6) begin bad++; $display("FAIL wrap_cnt got=%0d exp=6", fetch_count); end
      step();
      total++; if (rom_addr !== 16'h0002 || id_inst !== 16'h1111) begin bad++; $display("FAIL wrap_next got=%h/%h exp=0002/1111", rom_addr, id_inst); end
      // Reset must override a simultaneous branch and stall.
      rst = 1'b1; branch_flag = 1'b1; stall = 1'b1; branch_target = 16'h0081;
      step();
      total++; if (rom_ce !== 1'b0 || rom_addr !== 16'h0000) begin bad++; $display("FAIL mrst_ce_addr got=%b/%h exp=0/0000", rom_ce, rom_addr); end
      total++; if (id_valid !== 1'b0 || id_inst !== 16'h0000 || id_pc !== 16'h0000)
         begin bad++; $display("FAIL mrst_id got=%b/%h/%h exp=0/0000/0000", id_valid, id_inst, id_pc); end
      total++; if (fetch_count !== 16'h0000 || misalign_err !== 1'b0) begin bad++; $display("FAIL mrst_cnt_mis got=%0d/%b exp=0/0", fetch_count, misalign_err); end
      rst = 1'b0; branch_flag = 1'b0; stall = 1'b0;
      step();
      total++; if (rom_ce !== 1'b1 || rom_addr !== 16'h0000 || id_valid !== 1'b0)
         begin bad++; $display("FAIL mrst_bubble got=%b/%h/%b exp=1/0000/0", rom_ce, rom_addr, id_valid); end
      step();
      total++; if (id_inst !== 16'h1111 || fetch_count !== 16'd1) begin bad++; $display("FAIL mrst_restart got=%h/%0d exp=1111/1", id_inst, fetch_count); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_stall();
      test_branch();
      test_misalign();
      test_wrap_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
